keypad_scan_ctrl: RTL and testbench

Sequencing controller for the 4x4 matrix keypad. It drives the column lines one at a time and samples the row lines through a synchronizer. It debounces a detected press, then presents the press to the keypad decode LUT as a one-hot `{row, col}` code with a single-cycle `key_valid` strobe. It sits between the keypad I/O pins and the LUT, and it is the only block that touches the keypad pins.

---
 rtl/keypad_scan_ctrl.sv | 178 +++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
// Column-scanning, debouncing controller for a 4x4 matrix keypad. It walks a
// one-hot column drive, samples the synchronized rows, and debounces a press.
// It then reports the key as a one-hot {row, col} code with a single-cycle
// key_valid strobe, and keeps key_held high until the key is released.
//
// Build option: define KEYPAD_MULTI_REJECT_EN to treat any sample with more
// than one row bit set as "no press". Without it, the lowest set row wins.

module keypad_scan_ctrl #(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [7:0] key_out,
  output logic       key_valid,
  output logic       key_held
);

  // The dwell, debounce and release phases never overlap, so they share one counter.
  localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    rowsMeta_q, rowsS_q;
  logic [3:0]    cols_q, cols_d;
  logic [3:0]    rowCap_q, rowCap_d;
  logic [3:0]    colCap_q, colCap_d;
  logic [7:0]    keyOut_q, keyOut_d;
  logic          keyValid_q, keyValid_d;
  logic          keyHeld_q, keyHeld_d;

  logic          pressDetect;
  logic          rowStill;
  logic [3:0]    rowPick;
  logic [3:0]    colsNext;

  // Rotating the column drive is the same step for idle scans, rejects and releases.
  assign colsNext = {cols_q[2:0], cols_q[3]};

`ifdef KEYPAD_MULTI_REJECT_EN
  // Only a clean single-row sample counts, and it must stay exactly that row.
  assign pressDetect = $onehot(rowsS_q);
  assign rowPick     = rowsS_q;
  assign rowStill    = (rowsS_q == rowCap_q);
`else
  assign pressDetect = |rowsS_q;
  assign rowStill    = |(rowsS_q & rowCap_q);

  // Ghosted multi-row samples resolve to the lowest-index set row.
  always_comb begin
    rowPick = 4'b0000;
    if (rowsS_q[0])      rowPick = 4'b0001;
    else if (rowsS_q[1]) rowPick = 4'b0010;
    else if (rowsS_q[2]) rowPick = 4'b0100;
    else if (rowsS_q[3]) rowPick = 4'b1000;
  end
`endif

  // Two-flop synchronizer for the asynchronous row pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      rowsMeta_q <= 4'b0000;
      rowsS_q    <= 4'b0000;
    end else begin
      rowsMeta_q <= rows;
      rowsS_q    <= rowsMeta_q;
    end
  end

  // Next-state logic for the scan / debounce / held sequencing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cols_d     = cols_q;
    rowCap_d   = rowCap_q;
    colCap_d   = colCap_q;
    keyOut_d   = keyOut_q;
    keyValid_d = 1'b0;
    keyHeld_d  = keyHeld_q;

    case (state_q)
      SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (pressDetect) begin
            rowCap_d = rowPick;
            colCap_d = cols_q;
            state_d  = DEBOUNCE;
          end else begin
            cols_d = colsNext;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (rowStill) begin
          if (cnt_q == DEB_LAST) begin
            state_d    = HELD;
            cnt_d      = '0;
            keyOut_d   = {rowCap_q, colCap_q};
            keyValid_d = 1'b1;
            keyHeld_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = SCAN;
          cnt_d   = '0;
          cols_d  = colsNext;
        end
      end

      HELD: begin
        if (|(rowsS_q & rowCap_q)) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = SCAN;
          cnt_d     = '0;
          cols_d    = colsNext;
          keyHeld_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = SCAN;
        cnt_d     = '0;
        cols_d    = 4'b0001;
        keyHeld_d = 1'b0;
      end
    endcase
  end

  // State, capture and output registers; every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SCAN;
      cnt_q      <= '0;
      cols_q     <= 4'b0001;
      rowCap_q   <= 4'b0000;
      colCap_q   <= 4'b0000;
      keyOut_q   <= 8'h00;
      keyValid_q <= 1'b0;
      keyHeld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cols_q     <= cols_d;
      rowCap_q   <= rowCap_d;
      colCap_q   <= colCap_d;
      keyOut_q   <= keyOut_d;
      keyValid_q <= keyValid_d;
      keyHeld_q  <= keyHeld_d;
    end
  end

  assign cols      = cols_q;
  assign key_out   = keyOut_q;
  assign key_valid = keyValid_q;
  assign key_held  = keyHeld_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl
// Self-checking bench for keypad_scan_ctrl with SCAN_CYCLES=4 and
// DEBOUNCE_CYCLES=8. Each press pushes its expected key onto a scoreboard
// queue. A monitor pops that key whenever key_valid fires. Timing expectations
// are counted from the cycle the stimulus is driven.

module tb_keypad_scan_ctrl;

  localparam int SCAN_CYCLES     = 4;
  localparam int DEBOUNCE_CYCLES = 8;
  // A press driven right as its column is entered is sampled at the end of the dwell.
  localparam int PRESS_LAT   = SCAN_CYCLES + DEBOUNCE_CYCLES;
  // Release counts start once the drop has crossed the two-flop synchronizer.
  localparam int RELEASE_LAT = 2 + DEBOUNCE_CYCLES;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [7:0] key_out;
  logic       key_valid;
  logic       key_held;

  int         checks = 0;
  int         passes = 0;
  logic [7:0] expQ[$];
  logic       prevValid = 1'b0;
  logic [7:0] lastKey = 8'h00;

  typedef struct {
    logic [3:0] rowsVal;
    logic [3:0] col;
    bit         expAccept;
    logic [7:0] expKey;
  } vec_t;

  vec_t vecs[4];

  keypad_scan_ctrl #(
    .SCAN_CYCLES    (SCAN_CYCLES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rows     (rows),
    .cols     (cols),
    .key_out  (key_out),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  function automatic logic [3:0] nextCol(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench one step after the edge on which cols switches to col.
  task automatic waitColEntry(input logic [3:0] col);
    int n;
    n = 0;
    while (cols == col && n < 64) begin waitCycles(1); n++; end
    while (cols != col && n < 64) begin waitCycles(1); n++; end
    if (n >= 64 || cols != col) begin
      checks++;
      $display("[TB] FAIL column wait: cols=%b, expected to enter %b", cols, col);
    end
  endtask

  task automatic pressKey(input logic [3:0] r, input logic [3:0] col, input logic [7:0] key);
    int lat;
    waitColEntry(col);
    rows = r;
    expQ.push_back(key);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      waitCycles(1);
      if (key_valid) begin
        lat = i;
        break;
      end
    end
    checkOutput("press latency", lat, PRESS_LAT);
    checkOutput("held on accept", 32'(key_held), 32'd1);
    checkOutput("cols frozen on accept", 32'(cols), 32'(col));
    lastKey = key;
  endtask

  task automatic releaseKey(input logic [3:0] col);
    rows = 4'b0000;
    waitCycles(RELEASE_LAT - 1);
    checkOutput("held just before release", 32'(key_held), 32'd1);
    waitCycles(1);
    checkOutput("held after release", 32'(key_held), 32'd0);
    checkOutput("scan resumes next col", 32'(cols), 32'(nextCol(col)));
    checkOutput("key_out kept after release", 32'(key_out), 32'(lastKey));
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.expAccept) begin
      pressKey(v.rowsVal, v.col, v.expKey);
      waitCycles(5);
      checkOutput("key_out stable while held", 32'(key_out), 32'(v.expKey));
      releaseKey(v.col);
    end else begin
      waitColEntry(v.col);
      rows = v.rowsVal;
      waitCycles(5);
      checkOutput("rejected sample advances col", 32'(cols), 32'(nextCol(v.col)));
      rows = 4'b0000;
      waitCycles(20);
      checkOutput("key_out unchanged on reject", 32'(key_out), 32'(lastKey));
      checkOutput("no hold on reject", 32'(key_held), 32'd0);
    end
  endtask

  // Scoreboard side: every strobe must be a single cycle and match the oldest pending key.
  always @(posedge clk) begin
    #1;
    if (key_valid) begin
      checkOutput("strobe width", 32'(prevValid), 32'd0);
      if (expQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected strobe: key_out=%02h, expected no strobe", key_out);
      end else begin
        checkOutput("strobe key", 32'(key_out), 32'(expQ.pop_front()));
      end
    end
    prevValid = key_valid;
  end

  // Hard stop so a stuck design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{rowsVal: 4'b0100, col: 4'b0010, expAccept: 1'b1, expKey: 8'b0100_0010};
    vecs[1] = '{rowsVal: 4'b1000, col: 4'b0001, expAccept: 1'b1, expKey: 8'b1000_0001};
`ifdef KEYPAD_MULTI_REJECT_EN
    vecs[2] = '{rowsVal: 4'b0011, col: 4'b0001, expAccept: 1'b0, expKey: 8'h00};
`else
    vecs[2] = '{rowsVal: 4'b0011, col: 4'b0001, expAccept: 1'b1, expKey: 8'b0001_0001};
`endif
    vecs[3] = '{rowsVal: 4'b0001, col: 4'b0100, expAccept: 1'b1, expKey: 8'b0001_0100};

    // Reset state and idle rotation.
    rows  = 4'b0000;
    reset = 1'b1;
    waitCycles(2);
    checkOutput("reset cols", 32'(cols), 32'h1);
    checkOutput("reset key_out", 32'(key_out), 32'h0);
    checkOutput("reset key_valid", 32'(key_valid), 32'h0);
    checkOutput("reset key_held", 32'(key_held), 32'h0);
    reset = 1'b0;
    waitCycles(3);
    checkOutput("idle dwell col0", 32'(cols), 32'h1);
    waitCycles(1);
    checkOutput("idle rotate col1", 32'(cols), 32'h2);
    waitCycles(4);
    checkOutput("idle rotate col2", 32'(cols), 32'h4);
    waitCycles(4);
    checkOutput("idle rotate col3", 32'(cols), 32'h8);
    waitCycles(4);
    checkOutput("idle wrap col0", 32'(cols), 32'h1);

    // Table-driven presses and releases.
    for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

    // Bounce: press on col 1000 drops after three good debounce cycles.
    waitColEntry(4'b1000);
    rows = 4'b0001;
    waitCycles(5);
    checkOutput("bounce cols frozen", 32'(cols), 32'h8);
    rows = 4'b0000;
    waitCycles(3);
    checkOutput("bounce resumes col0", 32'(cols), 32'h1);
    checkOutput("bounce key_out", 32'(key_out), 32'(lastKey));
    checkOutput("bounce no hold", 32'(key_held), 32'd0);
    waitCycles(12);

    // A second key while held is ignored.
    pressKey(4'b0010, 4'b0001, 8'b0010_0001);
    rows = 4'b1010;
    waitCycles(20);
    checkOutput("second key key_out", 32'(key_out), 32'h21);
    checkOutput("second key held", 32'(key_held), 32'd1);
    checkOutput("second key cols", 32'(cols), 32'h1);
    releaseKey(4'b0001);

    // A one-cycle glitch during release restarts the release count.
    pressKey(4'b1000, 4'b0001, 8'b1000_0001);
    rows = 4'b0000;
    waitCycles(5);
    rows = 4'b1000;
    waitCycles(1);
    rows = 4'b0000;
    waitCycles(4);
    checkOutput("glitch held at unglitched point", 32'(key_held), 32'd1);
    waitCycles(5);
    checkOutput("glitch held before restart end", 32'(key_held), 32'd1);
    waitCycles(1);
    checkOutput("glitch held released", 32'(key_held), 32'd0);
    checkOutput("glitch scan resumes", 32'(cols), 32'h2);

    // Reset while a key is held.
    pressKey(4'b0100, 4'b0010, 8'b0100_0010);
    waitCycles(2);
    reset = 1'b1;
    waitCycles(2);
    checkOutput("midreset cols", 32'(cols), 32'h1);
    checkOutput("midreset key_out", 32'(key_out), 32'h0);
    checkOutput("midreset key_valid", 32'(key_valid), 32'h0);
    checkOutput("midreset key_held", 32'(key_held), 32'h0);
    rows    = 4'b0000;
    reset   = 1'b0;
    lastKey = 8'h00;
    waitCycles(4);
    checkOutput("midreset scan restarts", 32'(cols), 32'h2);
    waitCycles(4);

    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
